exec_trace_monitor: RTL and testbench

- Synthesizable execution-trace monitor attached to the multicycle processing unit's debug outputs.
- Replaces free-running `$monitor` printing with a parametrised trace buffer. Each PC change and each data-memory store is recorded as a time-stamped entry.
- Provides a cycle counter and sticky halt detection (halt opcode or PC stall).
- The bench or a debug port drains entries through a pop interface.

---
 rtl/exec_trace_monitor_pkg.sv | 30 +++
 rtl/exec_trace_monitor_if.sv | 16 +
 rtl/exec_trace_monitor_fifo.sv | 62 ++++++
 rtl/exec_trace_monitor.sv | 152 +++++++++++++++
 tb/tb_exec_trace_monitor.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_trace_monitor_pkg.sv
// Shared types and constants for the execution-trace monitor.
// No logic: enums, the trace entry layout and the default halt opcode.
// Imported by the FIFO and the monitor top.
package trace_pkg;

  localparam int TRC_DATA_W  = 64;
  localparam int TRC_STAMP_W = 32;

  // ECALL/EBREAK-class SYSTEM opcode ends capture by default
  localparam logic [6:0] DEF_HALT_OPCODE = 7'b1110011;

  typedef enum logic {
    PC_EVT = 1'b0,
    ST_EVT = 1'b1
  } trace_kind_e;

  typedef enum logic [1:0] {
    H_NONE  = 2'b00,
    H_OPC   = 2'b01,
    H_STALL = 2'b10,
    H_BOTH  = 2'b11
  } halt_cause_e;

  typedef struct packed {
    trace_kind_e             kind;
    logic [TRC_DATA_W-1:0]   addr;
    logic [TRC_STAMP_W-1:0]  stamp;
  } trace_entry_t;

endpackage

// File: rtl/exec_trace_monitor_if.sv
// Trace drain port: first-word-fall-through head plus pop request.
// Head is combinational from buffer state; a pop takes effect at the next edge.
// Consumer pops only when rd_valid is high; pops on an empty buffer are ignored.
interface exec_trace_monitor_if #(
  parameter int DATA_W  = 64,
  parameter int STAMP_W = 32
);
  logic               rd_en;
  logic               rd_valid;
  logic               rd_kind;
  logic [DATA_W-1:0]  rd_addr;
  logic [STAMP_W-1:0] rd_stamp;

  modport master (input rd_en, output rd_valid, rd_kind, rd_addr, rd_stamp);
  modport slave  (output rd_en, input rd_valid, rd_kind, rd_addr, rd_stamp);
endinterface

// File: rtl/exec_trace_monitor_fifo.sv
// Circular trace store, DEPTH entries, first-word-fall-through read.
// Write visible at the head one edge after the write edge; pop at the edge.
// When full without a pop: mode 0 evicts the oldest entry, mode 1 drops the new one; drop pulses either way.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  entry_t                 wr_ent,
  input  logic                   rd_en,
  input  logic                   mode,
  output logic                   rd_valid,
  output entry_t                 rd_ent,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   drop
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             pop;
  logic             full;
  logic             do_wr;
  logic             evict;

  assign rd_valid = (fill != '0);
  // Empty buffer presents an all-zero head rather than stale storage
  assign rd_ent   = rd_valid ? mem[rptr] : '0;

  // Decide whether this cycle's write lands, evicts, or is lost
  always_comb begin
    pop   = rd_en && rd_valid;
    full  = (fill == (PTR_W+1)'(DEPTH));
    do_wr = wr_en && (!full || pop || !mode);
    evict = wr_en && full && !pop && !mode;
    drop  = wr_en && full && !pop;
  end

  // Entry storage; contents beyond fill are never presented
  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem[wptr] <= wr_ent;
  end

  // Pointers wrap naturally at DEPTH; fill tracks occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (pop || evict) rptr <= rptr + 1'b1;
      if (do_wr && !pop && !evict) fill <= fill + 1'b1;
      else if (pop && !do_wr)      fill <= fill - 1'b1;
    end
  end
endmodule

// File: rtl/exec_trace_monitor.sv
// Records PC changes and data stores of the multicycle core as stamped trace entries; detects halt.
// Entry reaches the buffer head one edge after its event (two for a store coinciding with a PC change).
// No backpressure to the core: entries that cannot be queued or pended are counted in dropped.
module exec_trace_monitor
  import trace_pkg::*;
#(
  parameter int                DATA_W       = 64,
  parameter int                DEPTH        = 16,
  parameter int                STAMP_W      = 32,
  parameter int                STATE_W      = 5,
  parameter logic [STATE_W-1:0] DECODE_STATE = 1,
  parameter logic [6:0]        HALT_OPCODE  = DEF_HALT_OPCODE,
  parameter int                STALL_LIMIT  = 64
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [DATA_W-1:0]      PCOut,
  input  logic [STATE_W-1:0]     state,
  input  logic [6:0]             Instr6_0,
  input  logic                   DMemWrite,
  input  logic [DATA_W-1:0]      ALUOut,
  input  logic                   trc_mode,
  exec_trace_monitor_if.master   rd,
  output logic [$clog2(DEPTH):0] fill,
  output logic [15:0]            dropped,
  output logic [63:0]            cycle_count,
  output logic                   halted,
  output logic [1:0]             halt_cause
);
  localparam int SCNT_W = $clog2(STALL_LIMIT) + 1;

  typedef struct packed {
    trace_kind_e        kind;
    logic [DATA_W-1:0]  addr;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  logic [DATA_W-1:0] prev_pc;
  logic [SCNT_W-1:0] stall_cnt;
  logic              pend_vld;
  entry_t            pend_ent;
  logic              pend_nxt_vld;
  entry_t            pend_nxt;
  logic              pc_evt;
  logic              opc_hit;
  logic              stall_hit;
  logic              wr_en;
  entry_t            wr_ent;
  entry_t            pc_ent;
  entry_t            st_ent;
  entry_t            head;
  logic              evt_drop;
  logic              fifo_drop;
  logic [16:0]       drop_sum;
  halt_cause_e       cause_q;

  // Event detection and the single-write arbitration: pending first, then PC, then store
  always_comb begin
    pc_evt       = (PCOut != prev_pc);
    pc_ent       = '{kind: PC_EVT, addr: PCOut,  stamp: cycle_count[STAMP_W-1:0]};
    st_ent       = '{kind: ST_EVT, addr: ALUOut, stamp: cycle_count[STAMP_W-1:0]};
    wr_en        = 1'b0;
    wr_ent       = '0;
    pend_nxt_vld = 1'b0;
    pend_nxt     = pend_ent;
    evt_drop     = 1'b0;
    if (halted) begin
      evt_drop = pend_vld;
    end else if (pend_vld) begin
      wr_en  = 1'b1;
      wr_ent = pend_ent;
      if (pc_evt) begin
        pend_nxt_vld = 1'b1;
        pend_nxt     = pc_ent;
        evt_drop     = DMemWrite;
      end else if (DMemWrite) begin
        pend_nxt_vld = 1'b1;
        pend_nxt     = st_ent;
      end
    end else if (pc_evt) begin
      wr_en  = 1'b1;
      wr_ent = pc_ent;
      if (DMemWrite) begin
        pend_nxt_vld = 1'b1;
        pend_nxt     = st_ent;
      end
    end else if (DMemWrite) begin
      wr_en  = 1'b1;
      wr_ent = st_ent;
    end
  end

  // Halt conditions evaluated on the current cycle's inputs
  always_comb begin
    opc_hit   = (state == DECODE_STATE) && (Instr6_0 == HALT_OPCODE);
    stall_hit = !pc_evt && (stall_cnt == SCNT_W'(STALL_LIMIT - 1));
    drop_sum  = {1'b0, dropped} + {16'd0, evt_drop} + {16'd0, fifo_drop};
  end

  // Cycle counter, PC history, stall counter and sticky halt; all freeze once halted
  always_ff @(posedge clk) begin
    if (Reset) begin
      cycle_count <= '0;
      prev_pc     <= '0;
      stall_cnt   <= '0;
      halted      <= 1'b0;
      cause_q     <= H_NONE;
    end else if (!halted) begin
      cycle_count <= cycle_count + 64'd1;
      prev_pc     <= PCOut;
      stall_cnt   <= pc_evt ? '0 : stall_cnt + 1'b1;
      if (opc_hit || stall_hit) begin
        halted  <= 1'b1;
        cause_q <= halt_cause_e'({stall_hit, opc_hit});
      end
    end
  end

  // Pending store/PC slot and saturating lost-entry counter
  always_ff @(posedge clk) begin
    if (Reset) begin
      pend_vld <= 1'b0;
      pend_ent <= '0;
      dropped  <= '0;
    end else begin
      pend_vld <= pend_nxt_vld;
      pend_ent <= pend_nxt;
      dropped  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (Reset),
    .wr_en    (wr_en),
    .wr_ent   (wr_ent),
    .rd_en    (rd.rd_en),
    .mode     (trc_mode),
    .rd_valid (rd.rd_valid),
    .rd_ent   (head),
    .fill     (fill),
    .drop     (fifo_drop)
  );

  assign rd.rd_kind  = head.kind;
  assign rd.rd_addr  = head.addr;
  assign rd.rd_stamp = head.stamp;
  assign halt_cause  = cause_q;
endmodule

// File: tb/tb_exec_trace_monitor.sv
module tb_exec_trace_monitor;
  localparam int DEPTH       = 16;
  localparam int STALL_LIMIT = 64;

  logic        clk = 1'b0;
  logic        Reset;
  logic [63:0] PCOut;
  logic [4:0]  state;
  logic [6:0]  Instr6_0;
  logic        DMemWrite;
  logic [63:0] ALUOut;
  logic        trc_mode;
  logic [4:0]  fill;
  logic [15:0] dropped;
  logic [63:0] cycle_count;
  logic        halted;
  logic [1:0]  halt_cause;

  exec_trace_monitor_if #(.DATA_W(64), .STAMP_W(32)) rdi();

  exec_trace_monitor #(
    .DATA_W(64), .DEPTH(DEPTH), .STAMP_W(32), .STATE_W(5),
    .DECODE_STATE(5'd1), .HALT_OPCODE(7'b1110011), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .Reset(Reset), .PCOut(PCOut), .state(state), .Instr6_0(Instr6_0),
    .DMemWrite(DMemWrite), .ALUOut(ALUOut), .trc_mode(trc_mode), .rd(rdi),
    .fill(fill), .dropped(dropped), .cycle_count(cycle_count),
    .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: the trace as a queue, the pending slot as a 0/1-length queue
  typedef struct {
    bit          kind;
    logic [63:0] addr;
    logic [31:0] stamp;
  } ment_t;

  ment_t       mq[$];
  ment_t       mpend[$];
  logic [63:0] m_cycle;
  bit          m_halted;
  bit [1:0]    m_cause;
  logic [63:0] m_prev;
  int          m_eq;
  int          m_drop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    ment_t cand[$];
    ment_t e;
    bit    pop;
    bit    opc;
    bit    stl;
    int    lost;
    if (Reset) begin
      mq.delete(); mpend.delete();
      m_cycle = 0; m_halted = 0; m_cause = 0; m_prev = 0; m_eq = 0; m_drop = 0;
      return;
    end
    pop  = rdi.rd_en && (mq.size() > 0);
    lost = 0;
    if (!m_halted) begin
      cand = mpend;
      mpend.delete();
      if (PCOut != m_prev) cand.push_back('{kind: 1'b0, addr: PCOut,  stamp: m_cycle[31:0]});
      if (DMemWrite)       cand.push_back('{kind: 1'b1, addr: ALUOut, stamp: m_cycle[31:0]});
    end else begin
      lost += mpend.size();
      mpend.delete();
    end
    if (pop) void'(mq.pop_front());
    if (cand.size() > 0) begin
      e = cand.pop_front();
      if (mq.size() < DEPTH) mq.push_back(e);
      else begin
        lost++;
        if (!trc_mode) begin
          void'(mq.pop_front());
          mq.push_back(e);
        end
      end
    end
    if (cand.size() > 0) mpend.push_back(cand.pop_front());
    lost  += cand.size();
    m_drop = (m_drop + lost > 65535) ? 65535 : m_drop + lost;
    if (!m_halted) begin
      m_eq = (PCOut == m_prev) ? m_eq + 1 : 0;
      opc  = (state == 5'd1) && (Instr6_0 == 7'b1110011);
      stl  = (m_eq >= STALL_LIMIT);
      if (opc || stl) begin
        m_halted = 1;
        m_cause  = {stl, opc};
      end
      m_cycle = m_cycle + 1;
      m_prev  = PCOut;
    end
  endtask

  task automatic compare();
    chk("rd_valid", rdi.rd_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("rd_kind",  rdi.rd_kind,  mq[0].kind);
      chk("rd_addr",  rdi.rd_addr,  mq[0].addr);
      chk("rd_stamp", rdi.rd_stamp, mq[0].stamp);
    end else begin
      chk("rd_kind_empty",  rdi.rd_kind,  0);
      chk("rd_addr_empty",  rdi.rd_addr,  0);
      chk("rd_stamp_empty", rdi.rd_stamp, 0);
    end
    chk("fill",        fill,        mq.size());
    chk("dropped",     dropped,     m_drop);
    chk("cycle_count", cycle_count, m_cycle);
    chk("halted",      halted,      m_halted);
    chk("halt_cause",  halt_cause,  m_cause);
  endtask

  task automatic cyc(input logic [63:0] pc, input logic st, input logic [63:0] sa, input logic re);
    PCOut = pc; DMemWrite = st; ALUOut = sa; rdi.rd_en = re;
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    Reset = 1'b1; state = '0; Instr6_0 = '0;
    cyc(64'h0, 1'b0, 64'h0, 1'b1);
    cyc(64'h0, 1'b0, 64'h0, 1'b1);
    Reset = 1'b0;
  endtask

  initial begin
    PCOut = '0; DMemWrite = 1'b0; ALUOut = '0; trc_mode = 1'b0; rdi.rd_en = 1'b0;

    // Two PC changes at cycles 3 and 8
    do_reset();
    chk("reset_fill", fill, 0);
    chk("reset_cycle", cycle_count, 0);
    for (int c = 0; c < 3; c++) cyc(64'h0, 0, 0, 0);
    for (int c = 3; c < 8; c++) cyc(64'h4, 0, 0, 0);
    cyc(64'h8, 0, 0, 0);
    chk("t1_fill", fill, 2);
    chk("t1_dropped", dropped, 0);
    chk("t1_head_addr", rdi.rd_addr, 64'h4);
    chk("t1_head_stamp", rdi.rd_stamp, 3);
    cyc(64'h8, 0, 0, 1);
    chk("t1_second_addr", rdi.rd_addr, 64'h8);
    chk("t1_second_stamp", rdi.rd_stamp, 8);
    cyc(64'h8, 0, 0, 1);
    chk("t1_drained", rdi.rd_valid, 0);

    // PC change and store together, then a second collision while the store is pending
    do_reset();
    for (int c = 0; c < 10; c++) cyc(64'h0, 0, 0, 0);
    cyc(64'h20, 1, 64'h100, 0);
    chk("t2_fill_a", fill, 1);
    chk("t2_head_kind", rdi.rd_kind, 0);
    chk("t2_head_addr", rdi.rd_addr, 64'h20);
    chk("t2_head_stamp", rdi.rd_stamp, 10);
    cyc(64'h24, 1, 64'h104, 0);
    chk("t2_fill_b", fill, 2);
    chk("t2_dropped", dropped, 1);
    cyc(64'h24, 0, 0, 1);
    chk("t2_st_kind", rdi.rd_kind, 1);
    chk("t2_st_addr", rdi.rd_addr, 64'h100);
    chk("t2_st_stamp", rdi.rd_stamp, 10);
    chk("t2_fill_c", fill, 2);
    cyc(64'h24, 0, 0, 1);
    chk("t2_pc2_addr", rdi.rd_addr, 64'h24);
    chk("t2_pc2_stamp", rdi.rd_stamp, 11);

    // Overflow, overwrite-oldest mode
    do_reset();
    trc_mode = 1'b0;
    for (int i = 0; i < 20; i++) cyc(64'(4 * (i + 1)), 0, 0, 0);
    chk("t3_fill", fill, 16);
    chk("t3_dropped", dropped, 4);
    chk("t3_head_addr", rdi.rd_addr, 64'd20);
    chk("t3_head_stamp", rdi.rd_stamp, 4);

    // Overflow, drop-new mode, then pop+write while full
    do_reset();
    trc_mode = 1'b1;
    for (int i = 0; i < 20; i++) cyc(64'(4 * (i + 1)), 0, 0, 0);
    chk("t4_fill", fill, 16);
    chk("t4_dropped", dropped, 4);
    chk("t4_head_addr", rdi.rd_addr, 64'd4);
    cyc(64'h1000, 0, 0, 1);
    chk("t4_popwr_fill", fill, 16);
    chk("t4_popwr_dropped", dropped, 4);
    chk("t4_popwr_head", rdi.rd_addr, 64'd8);
    for (int i = 0; i < 3; i++) cyc(64'h1000, 0, 0, 1);
    trc_mode = 1'b0;

    // Opcode halt at cycle 40 with a coinciding PC change and store
    do_reset();
    for (int c = 0; c < 40; c++) cyc(64'((c / 10 + 1) * 16), 0, 0, (c % 3) == 0);
    state = 5'd1; Instr6_0 = 7'b1110011;
    cyc(64'h500, 1, 64'h600, 0);
    state = 5'd0; Instr6_0 = 7'd0;
    chk("t5_halted", halted, 1);
    chk("t5_cause", halt_cause, 2'b01);
    chk("t5_cycle", cycle_count, 41);
    cyc(64'h504, 0, 0, 0);
    chk("t5_pend_lost", dropped, 1);
    for (int c = 0; c < 6; c++) cyc(64'(32'h508 + 4 * c), 1, 64'h700, 1);
    chk("t5_cycle_frozen", cycle_count, 41);

    // PC stall: constant from cycle 5 through cycle 68
    do_reset();
    for (int c = 0; c < 4; c++) cyc(64'h0, 0, 0, 0);
    for (int c = 4; c < 68; c++) cyc(64'h40, 0, 0, 0);
    chk("t6_not_yet", halted, 0);
    cyc(64'h40, 0, 0, 0);
    chk("t6_halted", halted, 1);
    chk("t6_cause", halt_cause, 2'b10);
    chk("t6_cycle", cycle_count, 69);
    cyc(64'h44, 0, 0, 0);
    chk("t6_cycle_frozen", cycle_count, 69);
    do_reset();
    chk("t6_rst_halted", halted, 0);
    chk("t6_rst_cause", halt_cause, 0);
    chk("t6_rst_fill", fill, 0);
    chk("t6_rst_valid", rdi.rd_valid, 0);
    chk("t6_rst_cycle", cycle_count, 0);
    cyc(64'h0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
